// File: rtl/c_gate_bus_pipe_v5_0_pkg.sv
// Shared definitions for the pipelined gate-bus: operation codes, the
// base-operator/inversion decode and the beat-count width.
package c_gate_bus_pipe_v5_0_pkg;

    localparam logic [2:0] C_AND  = 3'd0;
    localparam logic [2:0] C_NAND = 3'd1;
    localparam logic [2:0] C_OR   = 3'd2;
    localparam logic [2:0] C_NOR  = 3'd3;
    localparam logic [2:0] C_XOR  = 3'd4;
    localparam logic [2:0] C_XNOR = 3'd5;
    localparam logic [2:0] C_INV  = 3'd6;
    localparam logic [2:0] C_BUF  = 3'd7;

    localparam int C_COUNT_W = 8;
    localparam logic [C_COUNT_W-1:0] C_COUNT_ONE = 1;
    localparam logic [C_COUNT_W-1:0] C_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        BASE_AND,
        BASE_OR,
        BASE_XOR,
        BASE_BUF
    } base_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    function automatic base_op_t base_op(input logic [2:0] op);
        case (op)
            C_AND, C_NAND: base_op = BASE_AND;
            C_OR, C_NOR:   base_op = BASE_OR;
            C_XOR, C_XNOR: base_op = BASE_XOR;
            default:       base_op = BASE_BUF;
        endcase
    endfunction

    // Inversion is applied once at emission, never to individual beats.
    function automatic logic out_inv(input logic [2:0] op);
        out_inv = (op == C_NAND) || (op == C_NOR) || (op == C_XNOR) || (op == C_INV);
    endfunction

    function automatic int count_width();
        count_width = C_COUNT_W;
    endfunction

endpackage

// File: rtl/c_gate_bus_pipe_v5_0_reduce.sv
// Combinational per-channel inversion mask followed by an N-channel
// AND/OR/XOR reduction; BUF passes masked channel 0 through.
module c_gate_bus_reduce_v5_0
    import c_gate_bus_pipe_v5_0_pkg::*;
#(
    parameter int                            C_WIDTH    = 16,
    parameter int                            C_INPUTS   = 4,
    parameter logic [C_INPUTS*C_WIDTH-1:0]   C_INV_MASK = '0
)(
    input  logic [C_INPUTS*C_WIDTH-1:0] i_data,
    input  base_op_t                    i_base,
    output logic [C_WIDTH-1:0]          o_red
);

    logic [C_WIDTH-1:0] w_chan [C_INPUTS];

    genvar gi;
    generate
        for (gi = 0; gi < C_INPUTS; gi++) begin : g_mask
            assign w_chan[gi] = i_data[gi*C_WIDTH +: C_WIDTH] ^ C_INV_MASK[gi*C_WIDTH +: C_WIDTH];
        end
    endgenerate

    always_comb begin
        o_red = w_chan[0];
        for (int k = 1; k < C_INPUTS; k++) begin
            case (i_base)
                BASE_AND: o_red = o_red & w_chan[k];
                BASE_OR:  o_red = o_red | w_chan[k];
                BASE_XOR: o_red = o_red ^ w_chan[k];
                default:  o_red = o_red;
            endcase
        end
    end

endmodule

// File: rtl/c_gate_bus_pipe_v5_0.sv
// Pipelined gate-bus: per-beat masked reduction, optional frame fold,
// and a C_LATENCY-deep token pipeline behind a valid/ready handshake.
module c_gate_bus_pipe_v5_0
    import c_gate_bus_pipe_v5_0_pkg::*;
#(
    parameter int                            C_WIDTH     = 16,
    parameter int                            C_INPUTS    = 4,
    parameter logic [C_INPUTS*C_WIDTH-1:0]   C_INV_MASK  = '0,
    parameter int                            C_LATENCY   = 2,
    parameter logic [C_WIDTH-1:0]            C_SINIT_VAL = '0
)(
    input  logic                          CLK,
    input  logic                          ACLR_N,
    input  logic                          SINIT,
    input  logic [2:0]                    OP,
    input  logic                          ACC,
    input  logic                          S_VALID,
    output logic                          S_READY,
    input  logic                          S_LAST,
    input  logic [C_INPUTS*C_WIDTH-1:0]   I,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [C_WIDTH-1:0]            M_DATA,
    output logic [C_COUNT_W-1:0]          M_COUNT
);

    logic                 w_en;
    logic                 w_accept;
    logic [2:0]           w_red_op;
    logic [C_WIDTH-1:0]   w_red;
    logic [C_WIDTH-1:0]   w_fold;
    logic [C_COUNT_W-1:0] w_cnt_inc;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_op_q;
    logic [2:0]           w_op_next;
    logic [C_WIDTH-1:0]   r_acc;
    logic [C_WIDTH-1:0]   w_acc_next;
    logic [C_COUNT_W-1:0] r_cnt;
    logic [C_COUNT_W-1:0] w_cnt_next;

    logic                 w_emit_valid;
    logic [C_WIDTH-1:0]   w_emit_data;
    logic [C_COUNT_W-1:0] w_emit_cnt;

    // The whole pipe advances in lockstep; S_READY is deliberately combinational from M_READY.
    assign w_en     = !M_VALID || M_READY;
    assign S_READY  = w_en;
    assign w_accept = S_VALID && w_en && !SINIT;

    assign w_red_op = (r_state == ST_ACCUM) ? r_op_q : OP;

    c_gate_bus_reduce_v5_0 #(
        .C_WIDTH    (C_WIDTH),
        .C_INPUTS   (C_INPUTS),
        .C_INV_MASK (C_INV_MASK)
    ) u_reduce (
        .i_data (I),
        .i_base (base_op(w_red_op)),
        .o_red  (w_red)
    );

    always_comb begin
        case (base_op(r_op_q))
            BASE_AND: w_fold = r_acc & w_red;
            BASE_OR:  w_fold = r_acc | w_red;
            BASE_XOR: w_fold = r_acc ^ w_red;
            default:  w_fold = w_red;
        endcase
    end

    assign w_cnt_inc = (r_cnt == C_COUNT_MAX) ? r_cnt : r_cnt + C_COUNT_ONE;

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op_q;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_emit_valid = 1'b0;
        w_emit_data  = w_red;
        w_emit_cnt   = C_COUNT_ONE;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (ACC && (OP < C_INV) && !S_LAST) begin
                        w_state_next = ST_ACCUM;
                        w_op_next    = OP;
                        w_acc_next   = w_red;
                        w_cnt_next   = C_COUNT_ONE;
                    end else begin
                        w_emit_valid = 1'b1;
                        w_emit_data  = out_inv(OP) ? ~w_red : w_red;
                        w_emit_cnt   = C_COUNT_ONE;
                    end
                end
                ST_ACCUM: begin
                    if (S_LAST) begin
                        w_emit_valid = 1'b1;
                        w_emit_data  = out_inv(r_op_q) ? ~w_fold : w_fold;
                        w_emit_cnt   = w_cnt_inc;
                        w_state_next = ST_IDLE;
                        w_acc_next   = '0;
                        w_cnt_next   = '0;
                    end else begin
                        w_acc_next   = w_fold;
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            r_state <= ST_IDLE;
            r_op_q  <= C_AND;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (SINIT) begin
            r_state <= ST_IDLE;
            r_op_q  <= C_AND;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_op_q  <= w_op_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    logic                 w_stg_valid [C_LATENCY];
    logic [C_WIDTH-1:0]   w_stg_data  [C_LATENCY];
    logic [C_COUNT_W-1:0] w_stg_cnt   [C_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < C_LATENCY; gi++) begin : g_stage
            logic                 w_in_valid;
            logic [C_WIDTH-1:0]   w_in_data;
            logic [C_COUNT_W-1:0] w_in_cnt;
            logic                 r_valid;
            logic [C_WIDTH-1:0]   r_data;
            logic [C_COUNT_W-1:0] r_cnt_q;

            if (gi == 0) begin : g_head
                assign w_in_valid = w_emit_valid;
                assign w_in_data  = w_emit_data;
                assign w_in_cnt   = w_emit_cnt;
            end else begin : g_tail
                assign w_in_valid = w_stg_valid[gi-1];
                assign w_in_data  = w_stg_data[gi-1];
                assign w_in_cnt   = w_stg_cnt[gi-1];
            end

            // Payload only moves with a valid token so M_DATA keeps its last value across bubbles.
            always_ff @(posedge CLK or negedge ACLR_N) begin
                if (!ACLR_N) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_cnt_q <= '0;
                end else if (SINIT) begin
                    r_valid <= 1'b0;
                    r_data  <= C_SINIT_VAL;
                    r_cnt_q <= '0;
                end else if (w_en) begin
                    r_valid <= w_in_valid;
                    if (w_in_valid) begin
                        r_data  <= w_in_data;
                        r_cnt_q <= w_in_cnt;
                    end
                end
            end

            assign w_stg_valid[gi] = r_valid;
            assign w_stg_data[gi]  = r_data;
            assign w_stg_cnt[gi]   = r_cnt_q;
        end
    endgenerate

    assign M_VALID = w_stg_valid[C_LATENCY-1];
    assign M_DATA  = w_stg_data[C_LATENCY-1];
    assign M_COUNT = w_stg_cnt[C_LATENCY-1];

endmodule

// File: tb/tb_c_gate_bus_pipe_v5_0.sv
// Bench for c_gate_bus_pipe_v5_0: two instances (unmasked and masked) share
// stimulus and are scored against a frame-level reference model.
module tb_c_gate_bus_pipe_v5_0;

    localparam int          LAT     = 2;
    localparam logic [31:0] MASK_B  = 32'h0033_00FF;
    localparam logic [7:0]  SINIT_V = 8'hA5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        aclr_n, sinit, acc, s_valid, s_last, m_ready;
    logic [2:0]  op;
    logic [31:0] ibus;
    logic        s_ready_a, m_valid_a, s_ready_b, m_valid_b;
    logic [7:0]  m_data_a, m_count_a, m_data_b, m_count_b;

    c_gate_bus_pipe_v5_0 #(
        .C_WIDTH(8), .C_INPUTS(4), .C_INV_MASK(32'h0), .C_LATENCY(LAT), .C_SINIT_VAL(SINIT_V)
    ) dut_a (
        .CLK(clk), .ACLR_N(aclr_n), .SINIT(sinit), .OP(op), .ACC(acc),
        .S_VALID(s_valid), .S_READY(s_ready_a), .S_LAST(s_last), .I(ibus),
        .M_VALID(m_valid_a), .M_READY(m_ready), .M_DATA(m_data_a), .M_COUNT(m_count_a)
    );

    c_gate_bus_pipe_v5_0 #(
        .C_WIDTH(8), .C_INPUTS(4), .C_INV_MASK(MASK_B), .C_LATENCY(LAT), .C_SINIT_VAL(SINIT_V)
    ) dut_b (
        .CLK(clk), .ACLR_N(aclr_n), .SINIT(sinit), .OP(op), .ACC(acc),
        .S_VALID(s_valid), .S_READY(s_ready_b), .S_LAST(s_last), .I(ibus),
        .M_VALID(m_valid_b), .M_READY(m_ready), .M_DATA(m_data_b), .M_COUNT(m_count_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] da;
        logic [7:0] db;
        logic [7:0] cnt;
    } tok_t;

    typedef struct {
        logic [2:0]  op;
        logic        acc;
        logic        last;
        logic [31:0] bus;
        logic [7:0]  ea;
        logic [7:0]  eb;
    } vec_t;

    tok_t       exp_q[$];
    logic [7:0] beats_a[$];
    logic [7:0] beats_b[$];
    bit         in_frame = 1'b0;
    logic [2:0] f_op = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] comb2(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        if (o < 3'd2)      return a & b;
        else if (o < 3'd4) return a | b;
        else               return a ^ b;
    endfunction

    function automatic logic [7:0] m_red(input logic [31:0] bus, input logic [31:0] mask, input logic [2:0] o);
        logic [7:0] ch[4];
        logic [7:0] r;
        for (int k = 0; k < 4; k++) ch[k] = bus[k*8 +: 8] ^ mask[k*8 +: 8];
        if (o >= 3'd6) return ch[0];
        r = ch[0];
        for (int k = 1; k < 4; k++) r = comb2(r, ch[k], o);
        return r;
    endfunction

    function automatic bit inv_of(input logic [2:0] o);
        return (o == 3'd1) || (o == 3'd3) || (o == 3'd5) || (o == 3'd6);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        beats_a.delete();
        beats_b.delete();
        in_frame = 1'b0;
    endtask

    task automatic model_accept();
        logic [2:0] eo;
        logic [7:0] ra, rb, fa, fb;
        tok_t       t;
        eo = in_frame ? f_op : op;
        ra = m_red(ibus, 32'h0, eo);
        rb = m_red(ibus, MASK_B, eo);
        if (!in_frame) begin
            if (acc && (op < 3'd6) && !s_last) begin
                in_frame = 1'b1;
                f_op     = op;
                beats_a.push_back(ra);
                beats_b.push_back(rb);
            end else begin
                t.da  = inv_of(op) ? ~ra : ra;
                t.db  = inv_of(op) ? ~rb : rb;
                t.cnt = 8'd1;
                exp_q.push_back(t);
            end
        end else begin
            beats_a.push_back(ra);
            beats_b.push_back(rb);
            if (s_last) begin
                fa = beats_a[0];
                fb = beats_b[0];
                for (int k = 1; k < beats_a.size(); k++) begin
                    fa = comb2(fa, beats_a[k], f_op);
                    fb = comb2(fb, beats_b[k], f_op);
                end
                t.da  = inv_of(f_op) ? ~fa : fa;
                t.db  = inv_of(f_op) ? ~fb : fb;
                t.cnt = (beats_a.size() > 255) ? 8'd255 : 8'(beats_a.size());
                exp_q.push_back(t);
                beats_a.delete();
                beats_b.delete();
                in_frame = 1'b0;
            end
        end
    endtask

    // Called at a negedge with inputs already driven; scores the coming edge.
    task automatic tick();
        tok_t t;
        #1;
        if (m_valid_a && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_token actual=%h required=none", m_data_a);
            end else begin
                t = exp_q.pop_front();
                $display("tok data_a=%h data_b=%h count=%0d", m_data_a, m_data_b, m_count_a);
                check("tok_data_a", m_data_a, t.da);
                check("tok_data_b", m_data_b, t.db);
                check("tok_count_a", m_count_a, t.cnt);
                check("tok_valid_b", m_valid_b, 1'b1);
            end
        end
        if (sinit) model_clear();
        else if (s_valid && s_ready_a) model_accept();
        @(negedge clk);
    endtask

    task automatic wait_token(output int cyc);
        cyc = 0;
        while (!m_valid_a && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (!m_valid_a) begin
            errors++;
            $display("FAIL token_timeout actual=%0d required=<20", cyc);
        end
    endtask

    task automatic beat(input logic [2:0] o, input logic a, input logic l, input logic [31:0] b);
        op = o; acc = a; s_last = l; ibus = b; s_valid = 1'b1;
        tick();
    endtask

    vec_t vt[8];
    int   cyc;

    initial begin
        vt[0] = '{3'd0, 1'b1, 1'b1, 32'hFF3C0FFF, 8'h0C, 8'h00};
        vt[1] = '{3'd3, 1'b0, 1'b0, 32'h00000000, 8'hFF, 8'h00};
        vt[2] = '{3'd4, 1'b0, 1'b0, 32'h01020408, 8'h0F, 8'hC3};
        vt[3] = '{3'd1, 1'b0, 1'b0, 32'hFF3C0FFF, 8'hF3, 8'hFF};
        vt[4] = '{3'd2, 1'b0, 1'b1, 32'h00100001, 8'h11, 8'hFF};
        vt[5] = '{3'd5, 1'b0, 1'b0, 32'h01020408, 8'hF0, 8'h3C};
        vt[6] = '{3'd6, 1'b1, 1'b0, 32'hFFFFFF5A, 8'hA5, 8'h5A};
        vt[7] = '{3'd7, 1'b0, 1'b0, 32'h000000C3, 8'hC3, 8'h3C};

        aclr_n = 1'b1; sinit = 1'b0; acc = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1; op = 3'd0; ibus = 32'h0;
        #1 aclr_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid_a, 1'b0);
        check("rst_m_data", m_data_a, 8'h00);
        check("rst_m_count", m_count_a, 8'h00);
        check("rst_s_ready", s_ready_a, 1'b1);
        @(negedge clk);
        aclr_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            beat(vt[v].op, vt[v].acc, vt[v].last, vt[v].bus);
            s_valid = 1'b0;
            wait_token(cyc);
            check("vec_latency", cyc + 1, LAT);
            check("vec_data_a", m_data_a, vt[v].ea);
            check("vec_data_b", m_data_b, vt[v].eb);
            check("vec_count", m_count_a, 8'd1);
            tick();
        end

        beat(3'd4, 1'b1, 1'b0, 32'h00000001);
        beat(3'd0, 1'b0, 1'b0, 32'h00000002);
        beat(3'd0, 1'b0, 1'b1, 32'h00000004);
        s_valid = 1'b0;
        wait_token(cyc);
        check("fold_data_a", m_data_a, 8'h07);
        check("fold_data_b", m_data_b, 8'hCB);
        check("fold_count", m_count_a, 8'd3);
        tick();

        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) beat(3'd0, 1'b0, 1'b0, 32'hFFFFFF00 | k);
        s_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_s_ready", s_ready_a, 1'b0);
            check("stall_s_ready_b", s_ready_b, 1'b0);
            check("stall_m_valid", m_valid_a, 1'b1);
            if (exp_q.size() > 0) check("stall_m_data", m_data_a, exp_q[0].da);
            tick();
        end
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) beat(3'(k % 8), 1'b0, 1'b0, $urandom);
        s_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("drain_stall", exp_q.size(), 0);

        beat(3'd2, 1'b1, 1'b0, 32'h00000011);
        sinit = 1'b1;
        beat(3'd2, 1'b1, 1'b0, 32'h00000022);
        sinit = 1'b0; s_valid = 1'b0;
        check("sinit_m_valid", m_valid_a, 1'b0);
        check("sinit_m_data_a", m_data_a, SINIT_V);
        check("sinit_m_data_b", m_data_b, SINIT_V);
        check("sinit_m_count", m_count_a, 8'd0);
        beat(3'd7, 1'b0, 1'b0, 32'h00000011);
        s_valid = 1'b0;
        wait_token(cyc);
        check("post_sinit_data", m_data_a, 8'h11);
        check("post_sinit_count", m_count_a, 8'd1);
        tick();

        beat(3'd7, 1'b0, 1'b0, 32'h00000033);
        beat(3'd4, 1'b1, 1'b0, 32'h12345678);
        s_valid = 1'b0;
        #2 aclr_n = 1'b0;
        #1;
        check("aclr_m_valid", m_valid_a, 1'b0);
        check("aclr_m_data", m_data_a, 8'h00);
        check("aclr_m_count", m_count_a, 8'h00);
        check("aclr_s_ready", s_ready_a, 1'b1);
        model_clear();
        @(negedge clk);
        aclr_n = 1'b1;
        beat(3'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
        s_valid = 1'b0;
        wait_token(cyc);
        check("post_aclr_count", m_count_a, 8'd1);
        tick();

        for (int k = 0; k < 300; k++)
            beat(3'd0, 1'b1, (k == 299), (k == 100) ? 32'hFFFFFF7F : 32'hFFFFFFFF);
        s_valid = 1'b0;
        wait_token(cyc);
        check("sat_count_a", m_count_a, 8'd255);
        check("sat_count_b", m_count_b, 8'd255);
        check("sat_data_a", m_data_a, 8'h7F);
        check("sat_data_b", m_data_b, 8'h00);
        tick();

        for (int k = 0; k < 1500; k++) begin
            s_valid = ($urandom % 4) != 0;
            op      = 3'($urandom % 8);
            acc     = 1'($urandom % 2);
            s_last  = ($urandom % 3) == 0;
            ibus    = $urandom;
            m_ready = ($urandom % 4) != 0;
            sinit   = ($urandom % 64) == 0;
            tick();
        end
        sinit = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("drain_random", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
